// File: rtl/mac_pkg.sv
// Shared definitions for the 8-bit MAC processing elements and their operand feeder.
package mac_pkg;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 22;
    localparam int ADDR_W  = 6;
    localparam int MAX_LEN = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_ACC,
        ST_WAIT,
        ST_OUT
    } feeder_state_t;

    typedef logic signed [DATA_W-1:0] operand_t;
    typedef logic signed [ACC_W-1:0]  result_t;

endpackage

// File: rtl/mac_operand_stage.sv
// One-entry operand holder between the operand SRAMs and the MAC.
// SRAM return data normally flows straight to the MAC in its return cycle;
// if that cycle is stalled, the pair is parked here and replayed once en returns,
// so no element is dropped or presented twice.
module mac_operand_stage
    import mac_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     en,
    input  logic     issue,
    input  operand_t rd_weight,
    input  operand_t rd_activation,
    output operand_t weight,
    output operand_t activation,
    output logic     data_valid,
    output logic     occupied
);

    logic     pending;
    logic     holding;
    operand_t hold_weight;
    operand_t hold_activation;

    // Track the read in flight and park its data when it lands during a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            pending         <= 1'b0;
            holding         <= 1'b0;
            hold_weight     <= '0;
            hold_activation <= '0;
        end else begin
            pending <= issue;
            if (pending && !en) begin
                holding         <= 1'b1;
                hold_weight     <= rd_weight;
                hold_activation <= rd_activation;
            end else if (holding && en) begin
                holding <= 1'b0;
            end
        end
    end

    // Parked pair takes priority; otherwise pass the SRAM return through
    always_comb begin
        weight     = '0;
        activation = '0;
        if (holding) begin
            weight     = hold_weight;
            activation = hold_activation;
        end else if (pending) begin
            weight     = rd_weight;
            activation = rd_activation;
        end
        data_valid = en && (holding || pending);
    end

    assign occupied = pending || holding;

endmodule

// File: rtl/mac_stream_feeder.sv
// Operand sequencer for one MAC PE: clears the accumulator, streams vec_len
// weight/activation pairs from the operand SRAMs, pulses acc, waits for the
// dot product and offers it downstream on a valid/ready port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; command fields latched on accept
// ST_CLEAR  | one enabled cycle of mac_reset
// ST_STREAM | one SRAM read pair per enabled cycle, idx 0..len-1
// ST_ACC    | drain last operand, then one enabled cycle of mac_acc
// ST_WAIT   | waiting for mac_output_valid, bounded by RESULT_TIMEOUT
// ST_OUT    | res_valid held until res_ready
module mac_stream_feeder
    import mac_pkg::*;
#(
    parameter int RESULT_TIMEOUT = 32
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     start,
    input  logic [ADDR_W:0]          vec_len,
    input  logic [ADDR_W-1:0]        w_base,
    input  logic [ADDR_W-1:0]        a_base,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     w_rd_en,
    output logic                     a_rd_en,
    output logic [ADDR_W-1:0]        w_rd_addr,
    output logic [ADDR_W-1:0]        a_rd_addr,
    input  logic [DATA_W-1:0]        w_rd_data,
    input  logic [DATA_W-1:0]        a_rd_data,
    output logic                     mac_reset,
    output logic                     mac_data_valid,
    output logic signed [DATA_W-1:0] mac_weight,
    output logic signed [DATA_W-1:0] mac_activation,
    output logic                     mac_acc,
    input  logic                     mac_output_valid,
    input  logic signed [ACC_W-1:0]  mac_output_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data
);

    localparam int               LEN_W    = ADDR_W + 1;
    localparam int               TMO_W    = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(RESULT_TIMEOUT - 1);

    feeder_state_t     state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] w_base_q;
    logic [ADDR_W-1:0] a_base_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              stage_occupied;
    logic              last_read;

    assign last_read = (idx == len_q - LEN_W'(1));

    // Sequencer: command latch, read index, result timeout and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            idx         <= '0;
            w_base_q    <= '0;
            a_base_q    <= '0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
            res_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && en) begin
                        len_q       <= (vec_len > LEN_MAX) ? LEN_MAX : vec_len;
                        w_base_q    <= w_base;
                        a_base_q    <= a_base;
                        idx         <= '0;
                        err_timeout <= 1'b0;
                        state       <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (en) begin
                        if (len_q == '0) begin
                            res_data <= '0;
                            state    <= ST_OUT;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (en) begin
                        if (last_read) begin
                            idx   <= '0;
                            state <= ST_ACC;
                        end else begin
                            idx <= idx + LEN_W'(1);
                        end
                    end
                end
                ST_ACC: begin
                    // acc must not overlap the final operand beat
                    if (en && !stage_occupied) begin
                        tmo_cnt <= TMO_LOAD;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result returned during a stall is still taken so it cannot be lost
                    if (mac_output_valid) begin
                        res_data <= mac_output_result;
                        state    <= ST_OUT;
                    end else if (en) begin
                        if (tmo_cnt == '0) begin
                            err_timeout <= 1'b1;
                            res_data    <= '0;
                            state       <= ST_OUT;
                        end else begin
                            tmo_cnt <= tmo_cnt - TMO_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign w_rd_en   = en && (state == ST_STREAM);
    assign a_rd_en   = w_rd_en;
    assign w_rd_addr = w_base_q + idx[ADDR_W-1:0];
    assign a_rd_addr = a_base_q + idx[ADDR_W-1:0];
    assign mac_reset = en && (state == ST_CLEAR);
    assign mac_acc   = en && (state == ST_ACC) && !stage_occupied;
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_OUT);
    assign done      = res_valid && res_ready;

    mac_operand_stage u_operand_stage (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .issue         (w_rd_en),
        .rd_weight     (w_rd_data),
        .rd_activation (a_rd_data),
        .weight        (mac_weight),
        .activation    (mac_activation),
        .data_valid    (mac_data_valid),
        .occupied      (stage_occupied)
    );

endmodule
